// File: rtl/sys_timer_sched_pkg.sv
// Shared definitions for the interval-timer scheduler: FSM states,
// timer slave register map and control-register bit masks.
package sys_timer_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PL   = 3'd1,
    PH   = 3'd2,
    CTRL = 3'd3,
    RUN  = 3'd4,
    ACK  = 3'd5,
    STOP = 3'd6
  } state_e;

  // Interval timer slave register addresses
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  // Control register bit masks
  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  localparam logic [15:0] CTRL_RUN_WORD = CTRL_START | CTRL_CONT | CTRL_ITO;

endpackage

// File: rtl/sys_timer_sched_chan.sv
// One virtual timer channel: counts scheduler ticks down from a reload value.
// Latency: expire_o pulses one cycle after the tick that reaches zero.
// Backpressure: none; a config write in the same cycle as a tick wins.
// Ports: clk/reset_n; tick_i tick pulse; wr_i config strobe (already decoded
// for this channel) with reload_i/periodic_i/enable_i; expire_o, active_o.
module sys_timer_sched_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] reload_i,
  input  logic             periodic_i,
  input  logic             enable_i,
  output logic             expire_o,
  output logic             active_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             active_q, active_d;
  logic             expire_q, expire_d;

  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    active_d   = active_q;
    expire_d   = 1'b0;
    if (wr_i) begin
      // A zero reload would never expire, so it never arms the channel.
      count_d    = reload_i;
      reload_d   = reload_i;
      periodic_d = periodic_i;
      active_d   = enable_i && (reload_i != '0);
    end else if (tick_i && active_q) begin
      if (count_q == CNT_W'(1)) begin
        expire_d = 1'b1;
        if (periodic_q) begin
          count_d = reload_q;
        end else begin
          active_d = 1'b0;
          count_d  = '0;
        end
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      active_q   <= 1'b0;
      expire_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      active_q   <= active_d;
      expire_q   <= expire_d;
    end
  end

  assign expire_o = expire_q;
  assign active_o = active_q;

endmodule

// File: rtl/sys_timer_sched.sv
// Masters the interval timer (program period, run continuous, ack each IRQ)
// and fans the resulting tick stream out to NUM_CH software timer channels.
// Latency: bus write 1 cycle after the triggering input; expiry 1 cycle after tick.
// Backpressure: none; start/stop outside IDLE/RUN are dropped.
// Ports: clk/reset_n; start/stop control pulses; tmr_* Avalon-MM master to the
// timer slave plus tmr_irq; ch_* channel config write; tick, ch_expire,
// ch_active, busy status outputs.
module sys_timer_sched
  import sys_timer_sched_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] TICK_PERIOD = 32'd49999,
  localparam int         SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq,
  input  logic              ch_wr,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [CNT_W-1:0]  ch_reload,
  input  logic              ch_periodic,
  input  logic              ch_enable,
  output logic              tick,
  output logic [NUM_CH-1:0] ch_expire,
  output logic [NUM_CH-1:0] ch_active,
  output logic              busy
);

  state_e      state_q;
  logic        cs_q;
  logic        wn_q;
  logic [2:0]  addr_q;
  logic [15:0] data_q;
  logic        tick_q;

  // Bus outputs are registered alongside the state transition, so the write
  // belonging to a state is on the bus for exactly the cycle spent in it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      cs_q   <= 1'b0;
      wn_q   <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= PL;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= ADDR_PERIODL;
            data_q  <= TICK_PERIOD[15:0];
          end
        end
        PL: begin
          state_q <= PH;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= ADDR_PERIODH;
          data_q  <= TICK_PERIOD[31:16];
        end
        PH: begin
          state_q <= CTRL;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= ADDR_CONTROL;
          data_q  <= CTRL_RUN_WORD;
        end
        CTRL: state_q <= RUN;
        RUN: begin
          // stop beats start beats irq; a losing irq is simply not serviced.
          if (stop) begin
            state_q <= STOP;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= ADDR_CONTROL;
            data_q  <= CTRL_STOP;
          end else if (start) begin
            state_q <= PL;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= ADDR_PERIODL;
            data_q  <= TICK_PERIOD[15:0];
          end else if (tmr_irq) begin
            state_q <= ACK;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= ADDR_STATUS;
            data_q  <= 16'h0000;
            tick_q  <= 1'b1;
          end
        end
        ACK:     state_q <= RUN;
        STOP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_address    = addr_q;
  assign tmr_writedata  = data_q;
  assign tick           = tick_q;
  assign busy           = (state_q != IDLE) && (state_q != RUN);

  // Out-of-range ch_sel matches no instance, so the write is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = ch_wr && (int'(ch_sel) == i);

    sys_timer_sched_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick_i    (tick_q),
      .wr_i      (wr_sel),
      .reload_i  (ch_reload),
      .periodic_i(ch_periodic),
      .enable_i  (ch_enable),
      .expire_o  (ch_expire[i]),
      .active_o  (ch_active[i])
    );
  end

endmodule

// File: tb/tb_sys_timer_sched.sv
// Scoreboard bench for sys_timer_sched with a minimal interval-timer model:
// stimulus pushes expected bus writes and channel expiries, a negedge monitor
// pops and compares whenever the DUT drives the bus or pulses ch_expire.
module tb_sys_timer_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              stop;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [15:0]       tmr_writedata;
  logic              tmr_irq;
  logic              ch_wr;
  logic [1:0]        ch_sel;
  logic [CNT_W-1:0]  ch_reload;
  logic              ch_periodic;
  logic              ch_enable;
  logic              tick;
  logic [NUM_CH-1:0] ch_expire;
  logic [NUM_CH-1:0] ch_active;
  logic              busy;

  logic              irq_req;

  sys_timer_sched #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .TICK_PERIOD(32'd49999)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .tmr_address   (tmr_address),
    .tmr_chipselect(tmr_chipselect),
    .tmr_write_n   (tmr_write_n),
    .tmr_writedata (tmr_writedata),
    .tmr_irq       (tmr_irq),
    .ch_wr         (ch_wr),
    .ch_sel        (ch_sel),
    .ch_reload     (ch_reload),
    .ch_periodic   (ch_periodic),
    .ch_enable     (ch_enable),
    .tick          (tick),
    .ch_expire     (ch_expire),
    .ch_active     (ch_active),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer model: irq is a level raised on request, cleared by a write to
  // status or to either period register.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmr_irq <= 1'b0;
    else if (tmr_chipselect && !tmr_write_n &&
             (tmr_address == 3'd0 || tmr_address == 3'd2 || tmr_address == 3'd3))
      tmr_irq <= 1'b0;
    else if (irq_req) tmr_irq <= 1'b1;
  end

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        tk;
  } bus_exp_t;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] n;
    logic [3:0]  active;
  } exp_exp_t;

  bus_exp_t    bus_q[$];
  exp_exp_t    exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] obs_ticks = 0;
  logic [31:0] n_ticks = 0;
  logic        prev_tick = 1'b0;
  bus_exp_t    be;
  exp_exp_t    ee;

  // Monitor
  always @(negedge clk) begin
    if (ch_expire != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL expire_unexpected got mask=%b after_tick=%0d", ch_expire, obs_ticks);
      end else begin
        ee = exp_q.pop_front();
        if ({ch_expire, obs_ticks, prev_tick, ch_active} !== {ee.mask, ee.n, 1'b1, ee.active}) begin
          failures++;
          $display("FAIL expire got mask=%b tick=%0d prev_tick=%b active=%b exp mask=%b tick=%0d prev_tick=1 active=%b",
                   ch_expire, obs_ticks, prev_tick, ch_active, ee.mask, ee.n, ee.active);
        end
      end
    end
    prev_tick = tick;
    if (tick) obs_ticks = obs_ticks + 1;
    if (tmr_chipselect) begin
      checks++;
      if (bus_q.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected got addr=%0d data=%h tick=%b", tmr_address, tmr_writedata, tick);
      end else begin
        be = bus_q.pop_front();
        if ({tmr_write_n, tmr_address, tmr_writedata, tick} !== {1'b0, be.addr, be.data, be.tk}) begin
          failures++;
          $display("FAIL bus_write got we_n=%b addr=%0d data=%h tick=%b exp we_n=0 addr=%0d data=%h tick=%b",
                   tmr_write_n, tmr_address, tmr_writedata, tick, be.addr, be.data, be.tk);
        end
      end
    end else begin
      checks++;
      if (tmr_write_n !== 1'b1 || tick !== 1'b0) begin
        failures++;
        $display("FAIL bus_idle got we_n=%b tick=%b exp we_n=1 tick=0", tmr_write_n, tick);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_bus(input logic [2:0] a, input logic [15:0] d, input logic t);
    bus_exp_t e;
    e.addr = a; e.data = d; e.tk = t;
    bus_q.push_back(e);
  endtask

  task automatic push_exp(input logic [3:0] m, input logic [31:0] n, input logic [3:0] act);
    exp_exp_t e;
    e.mask = m; e.n = n; e.active = act;
    exp_q.push_back(e);
  endtask

  // Ends on the negedge of the PL cycle.
  task automatic do_start();
    push_bus(3'd2, 16'hC34F, 1'b0);
    push_bus(3'd3, 16'h0000, 1'b0);
    push_bus(3'd1, 16'h0007, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [15:0] rl, input logic per, input logic en);
    ch_wr = 1'b1; ch_sel = sel; ch_reload = rl; ch_periodic = per; ch_enable = en;
    cyc();
    ch_wr = 1'b0;
  endtask

  // One serviced irq; optionally drives a channel write in the ACK cycle.
  task automatic do_tick(input logic wr, input logic [1:0] sel, input logic [15:0] rl,
                         input logic per, input logic en);
    push_bus(3'd0, 16'h0000, 1'b1);
    n_ticks = n_ticks + 1;
    irq_req = 1'b1;
    cyc();
    irq_req = 1'b0;
    cyc();
    if (wr) begin
      ch_wr = 1'b1; ch_sel = sel; ch_reload = rl; ch_periodic = per; ch_enable = en;
    end
    cyc();
    ch_wr = 1'b0;
    cyc(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; irq_req = 1'b0;
    ch_wr = 1'b0; ch_sel = '0; ch_reload = '0; ch_periodic = 1'b0; ch_enable = 1'b0;
    cyc(2);
    check("rst_bus", {12'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
          {12'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
    check("rst_out", {22'd0, tick, ch_expire, ch_active, busy}, 32'd0);
    reset_n = 1'b1;
    cyc(2);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Program sequence: busy through PL/PH/CTRL, low in RUN
    do_start();
    check("busy_pl", {31'd0, busy}, 32'd1);
    cyc(); check("busy_ph", {31'd0, busy}, 32'd1);
    cyc(); check("busy_ctrl", {31'd0, busy}, 32'd1);
    cyc(); check("busy_run", {31'd0, busy}, 32'd0);

    // Single serviced irq
    do_tick(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    check("irq_cleared", {31'd0, tmr_irq}, 32'd0);
    check("run_after_ack", {31'd0, busy}, 32'd0);

    // Channels: ch0 one-shot 3, ch1 periodic 2, ch2 reload 0 stays inactive
    cfg(2'd0, 16'd3, 1'b0, 1'b1);
    cfg(2'd1, 16'd2, 1'b1, 1'b1);
    check("active_cfg", {28'd0, ch_active}, {28'd0, 4'b0011});
    cfg(2'd2, 16'd0, 1'b1, 1'b1);
    check("active_zero_reload", {28'd0, ch_active}, {28'd0, 4'b0011});

    // Ticks 2..14; ch1 rewritten with reload 3 during tick 5
    for (int k = 2; k <= 14; k++) begin
      case (k)
        3:  push_exp(4'b0010, 32'd3, 4'b0011);
        4:  push_exp(4'b0001, 32'd4, 4'b0010);
        8:  push_exp(4'b0010, 32'd8, 4'b0010);
        11: push_exp(4'b0010, 32'd11, 4'b0010);
        14: push_exp(4'b0010, 32'd14, 4'b0010);
        default: ;
      endcase
      do_tick(k == 5, 2'd1, 16'd3, 1'b1, 1'b1);
    end
    check("active_after", {28'd0, ch_active}, {28'd0, 4'b0010});
    check("tick_count", obs_ticks, n_ticks);

    // stop coinciding with irq: stop wins, no tick
    push_bus(3'd1, 16'h0008, 1'b0);
    irq_req = 1'b1;
    cyc();
    irq_req = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("busy_stop", {31'd0, busy}, 32'd1);
    cyc();
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("irq_pending", {31'd0, tmr_irq}, 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;
    cyc(4);
    do_start();
    cyc(3);
    check("irq_cleared_by_prog", {31'd0, tmr_irq}, 32'd0);
    check("busy_run2", {31'd0, busy}, 32'd0);

    // ch1 held its count (3) while stopped: expires on the third new tick
    for (int k = 15; k <= 17; k++) begin
      if (k == 17) push_exp(4'b0010, 32'd17, 4'b0010);
      do_tick(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    end

    // Reset during PH: bus idles immediately
    push_bus(3'd2, 16'hC34F, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_bus", {12'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
          {12'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
    check("rst_mid_out", {22'd0, tick, ch_expire, ch_active, busy}, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc(6);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_active", {28'd0, ch_active}, 32'd0);

    cyc(3);
    check("bus_q_empty", bus_q.size(), 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
